tdc_readout: RTL and testbench

- Consumer end of the TDC merge stage: captures each merged measurement word when the `done` pulse fires and queues it in a FIFO.
- Drains the FIFO over a UART 8N1 serial line to the host.
- Sits between the merge stage's `out`/`done` outputs and the board UART TX pin, all in the `clk` domain.

---
 rtl/tdc_readout_if.sv | 17 +
 rtl/tdc_readout.sv | 185 ++++++++++++++++++
 tb/tb_tdc_readout.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_readout_if.sv
// Bundles the merge-stage capture inputs and the UART/status outputs of tdc_readout.
// The master side drives din/done/clr_ovf and the slave side (the readout) drives the rest.
interface tdc_readout_if #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
);
  logic [DATA_W-1:0]      din;
  logic                   done;
  logic                   clr_ovf;
  logic                   tx;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;

  modport master (output din, done, clr_ovf, input tx, busy, fifo_count, overflow);
  modport slave  (input din, done, clr_ovf, output tx, busy, fifo_count, overflow);
endinterface

// File: rtl/tdc_readout.sv
// TDC readout: captures merged words on the rising edge of done into a FIFO and ships
// them MSB-byte-first over UART 8N1. Define READOUT_HEADER_EN to prefix each word with 0xA5.
module tdc_readout #(
  parameter int DATA_W       = 24,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         irst_n,
  tdc_readout_if.slave bus
);
  localparam int NB = (DATA_W + 7) / 8;
  localparam int WW = 8 * NB;
`ifdef READOUT_HEADER_EN
  localparam int NBT = NB + 1;
`else
  localparam int NBT = NB;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(NBT) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [WW-1:0]   word_q, word_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic       push_s, pop_s, accept_s, drop_s, baud_end_s;
  logic [7:0] cur_byte_s;

  // Byte idx of the current frame; with the header enabled, idx 0 is the sync byte.
  function automatic logic [7:0] byte_sel(input logic [WW-1:0] w, input logic [IW-1:0] idx);
    logic [7:0] res;
    int         pos;
`ifdef READOUT_HEADER_EN
    if (idx == IW'(0)) begin
      res = 8'hA5;
    end else begin
      pos = NB - int'(idx);
      res = w[8*pos +: 8];
    end
`else
    pos = NB - 1 - int'(idx);
    res = w[8*pos +: 8];
`endif
    return res;
  endfunction

  // Capture edge detect and FIFO bookkeeping.
  always_comb begin
    done_d     = bus.done;
    push_s     = bus.done & ~done_q;
    pop_s      = (state_q == IDLE) && (count_q != CW'(0));
    accept_s   = push_s && ((count_q < CW'(DEPTH)) || pop_s);
    drop_s     = push_s && !accept_s;
    wptr_d     = accept_s ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d     = pop_s ? (rptr_q + AW'(1)) : rptr_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // UART transmit FSM; tx and busy are computed from next-state values so they register in step.
  always_comb begin
    baud_end_s = (baud_q == BW'(CLKS_PER_BIT - 1));
    state_d    = state_q;
    baud_d     = baud_end_s ? {BW{1'b0}} : (baud_q + BW'(1));
    bit_d      = bit_q;
    idx_d      = idx_q;
    word_d     = word_q;
    case (state_q)
      IDLE: begin
        baud_d = {BW{1'b0}};
        if (pop_s) begin
          word_d  = WW'(mem_q[rptr_q]);
          idx_d   = {IW{1'b0}};
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (baud_end_s && (bit_q == 3'd7)) begin
          state_d = STOP;
        end else if (baud_end_s) begin
          bit_d = bit_q + 3'd1;
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (baud_end_s && (idx_q < IW'(NBT - 1))) begin
          idx_d   = idx_q + IW'(1);
          state_d = START;
        end else if (baud_end_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = {BW{1'b0}};
      end
    endcase
    cur_byte_s = byte_sel(word_d, idx_d);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte_s[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || (count_d != CW'(0));
  end

  // State and status registers.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= IDLE;
      baud_q  <= {BW{1'b0}};
      bit_q   <= 3'd0;
      idx_q   <= {IW{1'b0}};
      word_q  <= {WW{1'b0}};
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers and count gate every read.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wptr_q] <= bus.din;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_tdc_readout.sv
// Randomized bench for tdc_readout: a queue/timeline model predicts FIFO state and the byte
// stream, and a UART receiver decodes tx independently. Honours READOUT_HEADER_EN.
module tb_tdc_readout;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 4;
  localparam int CPB    = 4;
  localparam int NB     = 3;
`ifdef READOUT_HEADER_EN
  localparam int NBT = NB + 1;
  localparam int OFF = 1;
`else
  localparam int NBT = NB;
  localparam int OFF = 0;
`endif
  localparam int FRAME = NBT * 10 * CPB;

  logic clk = 1'b0;
  logic irst_n = 1'b0;
  always #5 clk = ~clk;

  tdc_readout_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  tdc_readout #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .irst_n(irst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, transmitter as a busy-until timeline.
  int                cyc = 0;
  int                next_free = 0;
  bit                m_prev = 1'b0, m_ovf = 1'b0, m_push, m_pop, m_drop;
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_w;
  logic [31:0]       m_tmp;
  logic [7:0]        exp_bytes[$];

  always @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      m_q.delete();
      exp_bytes.delete();
      m_prev = 1'b0;
      m_ovf = 1'b0;
      next_free = 0;
    end else begin
      cyc++;
      m_push = bus.done && !m_prev;
      m_prev = bus.done;
      m_pop = (cyc >= next_free) && (m_q.size() > 0);
      m_drop = 1'b0;
      if (m_pop) begin
        m_w = m_q.pop_front();
`ifdef READOUT_HEADER_EN
        exp_bytes.push_back(8'hA5);
`endif
        for (int k = NB - 1; k >= 0; k--) begin
          m_tmp = 32'(m_w) >> (8 * k);
          exp_bytes.push_back(m_tmp[7:0]);
        end
        next_free = cyc + FRAME + 1;
      end
      if (m_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.din);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (bus.clr_ovf) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (irst_n) begin
      chk_eq("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
      chk_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk_eq("busy", 32'(bus.busy), 32'((cyc + 1 < next_free) || (m_q.size() != 0)));
    end
  end

  // UART receiver sampling mid-bit on the falling clock edge.
  bit         mon_active = 1'b0;
  bit         prev_tx = 1'b1;
  int         mon_cnt, mon_b;
  logic [7:0] mon_byte;
  logic [7:0] rx_log[$];
  int         rx_start[$];

  always @(negedge clk) begin
    if (!irst_n) begin
      mon_active = 1'b0;
      prev_tx = 1'b1;
    end else if (!mon_active) begin
      if (prev_tx && !bus.tx) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        rx_start.push_back(cyc);
      end
      prev_tx = bus.tx;
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        mon_b = mon_cnt / CPB;
        if (mon_b == 0) begin
          chk_eq("start_bit", 32'(bus.tx), 32'd0);
        end else if (mon_b <= 8) begin
          mon_byte[mon_b-1] = bus.tx;
        end else begin
          chk_eq("stop_bit", 32'(bus.tx), 32'd1);
          rx_log.push_back(mon_byte);
          chk_eq("rx_pending", 32'(exp_bytes.size() != 0), 32'd1);
          if (exp_bytes.size() != 0) chk_eq("rx_byte", 32'(mon_byte), 32'(exp_bytes.pop_front()));
          mon_active = 1'b0;
          prev_tx = bus.tx;
        end
      end
    end
  end

  task automatic pulse(input logic [DATA_W-1:0] d, output int cap);
    @(negedge clk);
    bus.din = d;
    bus.done = 1'b1;
    cap = cyc;
    @(negedge clk);
    bus.done = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((bus.busy || mon_active || exp_bytes.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain_timeout", 32'(n < 5000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  int cap, base, sbase, n;
  int rate[3] = '{3, 15, 50};

  initial begin
    bus.din = '0;
    bus.done = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_tx", 32'(bus.tx), 32'd1);
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_count", 32'(bus.fifo_count), 32'd0);
    chk_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    irst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single word: latency and byte order
    base = rx_log.size();
    sbase = rx_start.size();
    pulse(24'h12AB34, cap);
    drain();
    chk_eq("latency", 32'(rx_start[sbase] - cap), 32'd2);
    chk_eq("single_nbytes", 32'(rx_log.size() - base), 32'(NBT));
`ifdef READOUT_HEADER_EN
    chk_eq("single_hdr", 32'(rx_log[base]), 32'hA5);
`endif
    chk_eq("single_b0", 32'(rx_log[base+OFF]), 32'h12);
    chk_eq("single_b1", 32'(rx_log[base+OFF+1]), 32'hAB);
    chk_eq("single_b2", 32'(rx_log[base+OFF+2]), 32'h34);
    chk_eq("single_busy_end", 32'(bus.busy), 32'd0);

    // Long done: one capture only
    base = rx_log.size();
    @(negedge clk);
    bus.din = 24'h000001;
    bus.done = 1'b1;
    repeat (5) @(negedge clk);
    bus.done = 1'b0;
    drain();
    chk_eq("long_nbytes", 32'(rx_log.size() - base), 32'(NBT));
    chk_eq("long_b0", 32'(rx_log[base+OFF]), 32'h00);
    chk_eq("long_b1", 32'(rx_log[base+OFF+1]), 32'h00);
    chk_eq("long_b2", 32'(rx_log[base+OFF+2]), 32'h01);

    // Overflow: six pulses during the first frame
    base = rx_log.size();
    sbase = rx_start.size();
    for (int i = 1; i <= 6; i++) pulse(DATA_W'(i), cap);
    chk_eq("ovf_set", 32'(bus.overflow), 32'd1);
    chk_eq("ovf_full", 32'(bus.fifo_count), 32'd4);
    @(negedge clk);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    chk_eq("ovf_clr", 32'(bus.overflow), 32'd0);
    drain();
    chk_eq("ovf_nbytes", 32'(rx_log.size() - base), 32'(5 * NBT));
    chk_eq("ovf_last", 32'(rx_log[rx_log.size()-1]), 32'h05);
    chk_eq("gap_in_word", 32'(rx_start[sbase+1] - rx_start[sbase]), 32'(10 * CPB));
    chk_eq("gap_b2b", 32'(rx_start[sbase+NBT] - rx_start[sbase+NBT-1]), 32'(10 * CPB + 1));

    // Push coinciding with the IDLE pop while full
    base = rx_log.size();
    for (int i = 0; i < 5; i++) pulse(DATA_W'(32'h10 + i), cap);
    chk_eq("sim_full_before", 32'(bus.fifo_count), 32'd4);
    n = 0;
    while ((cyc + 1 != next_free) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("sim_align_timeout", 32'(n < 2000), 32'd1);
    bus.din = 24'h00C0DE;
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    chk_eq("sim_count", 32'(bus.fifo_count), 32'd4);
    chk_eq("sim_ovf", 32'(bus.overflow), 32'd0);
    drain();
    chk_eq("sim_nbytes", 32'(rx_log.size() - base), 32'(6 * NBT));
    chk_eq("sim_last", 32'(rx_log[rx_log.size()-1]), 32'hDE);

    // Randomized traffic at three capture rates
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 800; i++) begin
        @(negedge clk);
        bus.din = DATA_W'($urandom);
        bus.done = ($urandom_range(0, 99) < rate[ph]);
        bus.clr_ovf = ($urandom_range(0, 39) == 0);
      end
    end
    @(negedge clk);
    bus.done = 1'b0;
    bus.clr_ovf = 1'b0;
    drain();

    // Reset in the middle of a frame
    pulse(24'hFFFFFF, cap);
    repeat (60) @(negedge clk);
    #1 irst_n = 1'b0;
    #1;
    chk_eq("mid_rst_tx", 32'(bus.tx), 32'd1);
    chk_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    chk_eq("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    repeat (3) @(negedge clk);
    irst_n = 1'b1;
    base = rx_log.size();
    repeat (200) @(negedge clk);
    chk_eq("post_rst_no_frame", 32'(rx_log.size() - base), 32'd0);
    chk_eq("post_rst_tx", 32'(bus.tx), 32'd1);
    chk_eq("post_rst_busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
